// File: rtl/snn_pkg.sv
// Shared types and helpers for the spike event encoder.
// - NUM_CORES / NUM_NEURONS / IDX_W / FIFO_DEPTH / CNT_W : block dimensions
// - spike_evt_t  : one address event {core, neuron index}
// - enc_state_t  : scanner FSM states
// - lowest_set() : priority encoder returning the lowest set bit index
package snn_pkg;

  localparam int unsigned NUM_CORES   = 2;
  localparam int unsigned NUM_NEURONS = 256;
  localparam int unsigned IDX_W       = $clog2(NUM_NEURONS);
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned CNT_W       = 16;

  typedef struct packed {
    logic             core;
    logic [IDX_W-1:0] idx;
  } spike_evt_t;

  typedef enum logic [0:0] {ENC_IDLE, ENC_SCAN} enc_state_t;

  // Walk from the top down so the lowest set bit is the last one to win.
  // Returns 0 for an all-zero vector; callers test for zero separately.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Show-ahead event FIFO.
// - wb_clk_i / wb_rst_i : clock, asynchronous active-high reset
// - push / push_data    : write request and event; ignored when full
// - pop                 : read request; ignored when empty
// - pop_data            : event at the head (valid while !empty)
// - empty / full        : occupancy flags
module spike_evt_fifo
  import snn_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       push,
  input  spike_evt_t push_data,
  input  logic       pop,
  output spike_evt_t pop_data,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  spike_evt_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Cleared so the head output reads zero after reset.
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spike_event_encoder.sv
// Converts per-core spike vectors into a serial {core_id, neuron_idx} event stream.
// - wb_clk_i / wb_rst_i  : clock, asynchronous active-high reset
// - enable_calc_i[k]     : calc-step pulse; snapshots spike_neuron_k_i if core k is idle
// - spike_neuron_0/1_i   : per-core spike vectors, bit n = neuron n
// - evt_valid_o / evt_ready_i / evt_data_o : event stream, {core, idx}
// - frame_done_o[k]      : one-cycle pulse when core k's scan finishes
// - busy_o               : a snapshot is pending or the scanner is active
// - overrun_cnt_o        : saturating count of enable pulses dropped while pending
module spike_event_encoder
  import snn_pkg::*;
(
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NUM_CORES-1:0]   enable_calc_i,
  input  logic [NUM_NEURONS-1:0] spike_neuron_0_i,
  input  logic [NUM_NEURONS-1:0] spike_neuron_1_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [IDX_W:0]         evt_data_o,
  output logic [NUM_CORES-1:0]   frame_done_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       overrun_cnt_o
);

  enc_state_t             state;
  logic                   act;
  logic                   last_core;
  logic [NUM_CORES-1:0]   pend;
  logic [NUM_NEURONS-1:0] snap     [NUM_CORES];
  logic [NUM_NEURONS-1:0] spike_in [NUM_CORES];

  logic [NUM_NEURONS-1:0] snap_act;
  logic [IDX_W-1:0]       scan_idx;
  logic                   scan_hit;
  logic                   scan_end;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  spike_evt_t             push_evt;
  spike_evt_t             head_evt;

  logic [1:0]             drop_cnt;
  logic [CNT_W:0]         cnt_sum;
  logic [CNT_W-1:0]       cnt_next;

  assign spike_in[0] = spike_neuron_0_i;
  assign spike_in[1] = spike_neuron_1_i;

  assign snap_act = snap[act];
  assign scan_idx = lowest_set(snap_act);
  assign scan_hit = (state == ENC_SCAN) && (snap_act != '0);
  assign scan_end = (state == ENC_SCAN) && (snap_act == '0);
  assign push     = scan_hit && !fifo_full;
  assign push_evt = '{core: act, idx: scan_idx};

  // Both cores may drop a pulse on the same edge, so the increment is 0..2.
  assign drop_cnt = {1'b0, enable_calc_i[0] & pend[0]} + {1'b0, enable_calc_i[1] & pend[1]};
  assign cnt_sum  = {1'b0, overrun_cnt_o} + (CNT_W + 1)'(drop_cnt);
  assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  assign busy_o      = (|pend) || (state != ENC_IDLE);
  assign evt_valid_o = !fifo_empty;
  assign evt_data_o  = head_evt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ENC_IDLE;
      act           <= 1'b0;
      last_core     <= 1'b1;
      pend          <= '0;
      frame_done_o  <= '0;
      overrun_cnt_o <= '0;
      for (int k = 0; k < int'(NUM_CORES); k++) snap[k] <= '0;
    end else begin
      frame_done_o  <= '0;
      overrun_cnt_o <= cnt_next;

      // A pending core is never re-captured, so this cannot race the scan clear below.
      for (int k = 0; k < int'(NUM_CORES); k++) begin
        if (enable_calc_i[k] && !pend[k]) begin
          snap[k] <= spike_in[k];
          pend[k] <= 1'b1;
        end
      end

      case (state)
        ENC_IDLE: begin
          if (|pend) begin
            // Both pending: alternate away from the core served last.
            act   <= (&pend) ? ~last_core : pend[1];
            state <= ENC_SCAN;
          end
        end
        ENC_SCAN: begin
          if (scan_end) begin
            frame_done_o[act] <= 1'b1;
            pend[act]         <= 1'b0;
            last_core         <= act;
            if (pend[~act]) act <= ~act;
            else state <= ENC_IDLE;
          end else if (push) begin
            snap[act][scan_idx] <= 1'b0;
          end
        end
        default: state <= ENC_IDLE;
      endcase
    end
  end

  spike_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .push     (push),
    .push_data(push_evt),
    .pop      (evt_ready_i),
    .pop_data (head_evt),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_spike_event_encoder.sv
module tb_spike_event_encoder;
  import snn_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   en  = '0;
  logic [255:0] sp0 = '0;
  logic [255:0] sp1 = '0;
  logic         ready = 1'b0;
  logic         evt_valid;
  logic [8:0]   evt_data;
  logic [1:0]   fd;
  logic         busy;
  logic [15:0]  ovr;

  spike_event_encoder dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .enable_calc_i   (en),
    .spike_neuron_0_i(sp0),
    .spike_neuron_1_i(sp1),
    .evt_valid_o     (evt_valid),
    .evt_ready_i     (ready),
    .evt_data_o      (evt_data),
    .frame_done_o    (fd),
    .busy_o          (busy),
    .overrun_cnt_o   (ovr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cyc = 0;
  int model_ovr = 0;
  int done_cyc [2];

  // Model: the events and frame completions the spec says must appear, in order.
  logic [8:0] exp_q[$];
  int         exp_done_q[$];
  logic [8:0] log_evt[$];
  int         log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Per-cycle compare against the model queues.
  initial begin
    logic       prev_stall;
    logic [8:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(evt_valid), 1);
          check("hold_data", 32'(evt_data), 32'(prev_data));
        end
        if (evt_valid && ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_evt: got %0h, expected no event (cycle %0d)", evt_data, cyc);
          end else begin
            check("evt", 32'(evt_data), 32'(exp_q.pop_front()));
          end
          log_evt.push_back(evt_data);
          log_cyc.push_back(cyc);
        end
        for (int k = 0; k < 2; k++) begin
          if (fd[k]) begin
            done_cyc[k] = cyc;
            if (exp_done_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_done: got core %0d, expected none (cycle %0d)", k, cyc);
            end else begin
              check("done_core", 32'(k), 32'(exp_done_q.pop_front()));
            end
          end
        end
        check("overrun", 32'(ovr), 32'(model_ovr));
        prev_stall = evt_valid && !ready;
        prev_data  = evt_data;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fire(input logic [1:0] e, input logic [255:0] v0, input logic [255:0] v1);
    sp0 = v0;
    sp1 = v1;
    en  = e;
    tick();
    en     = '0;
    en_cyc = cyc;
  endtask

  task automatic add_frame(input int core, input logic [255:0] v);
    logic c;
    c = core[0];
    for (int i = 0; i < 256; i++) begin
      if (v[i]) exp_q.push_back({c, 8'(i)});
    end
    exp_done_q.push_back(core);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy || evt_valid || exp_q.size() != 0 || exp_done_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    tick();
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d events outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic clear_log();
    log_evt.delete();
    log_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [255:0] v;

    tick(2);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_data", 32'(evt_data), 0);
    check("rst_done", 32'(fd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovr", 32'(ovr), 0);
    rst = 1'b0;
    tick();

    // Both cores at once, core 0 first after reset.
    ready = 1'b1;
    clear_log();
    add_frame(0, 256'h1 << 7);
    add_frame(1, 256'h1 << 9);
    fire(2'b11, 256'h1 << 7, 256'h1 << 9);
    wait_idle(50, "both");
    check("both_cnt", 32'(log_evt.size()), 2);
    if (log_evt.size() == 2) begin
      check("both_e0", 32'(log_evt[0]), 32'h007);
      check("both_e1", 32'(log_evt[1]), 32'h109);
    end
    check("both_order", 32'(done_cyc[0] < done_cyc[1]), 1);
    check("both_done1_cyc", 32'(done_cyc[1]), 32'(en_cyc + 5));

    // Three bits on core 0, back-to-back events two cycles after the enable.
    clear_log();
    v = '0;
    v[3] = 1'b1;
    v[40] = 1'b1;
    v[255] = 1'b1;
    add_frame(0, v);
    fire(2'b01, v, '0);
    wait_idle(50, "three");
    check("three_cnt", 32'(log_evt.size()), 3);
    if (log_evt.size() == 3) begin
      check("three_e0", 32'(log_evt[0]), 32'h003);
      check("three_e1", 32'(log_evt[1]), 32'h028);
      check("three_e2", 32'(log_evt[2]), 32'h0ff);
      check("three_c0", 32'(log_cyc[0]), 32'(en_cyc + 2));
      check("three_c1", 32'(log_cyc[1]), 32'(en_cyc + 3));
      check("three_c2", 32'(log_cyc[2]), 32'(en_cyc + 4));
    end
    check("three_done_cyc", 32'(done_cyc[0]), 32'(en_cyc + 5));

    // All ones with the consumer stalled: FIFO fills, scanner waits, nothing lost.
    clear_log();
    ready = 1'b0;
    add_frame(0, '1);
    fire(2'b01, '1, '0);
    tick(40);
    check("full_busy", 32'(busy), 1);
    check("full_valid", 32'(evt_valid), 1);
    check("full_head", 32'(evt_data), 32'h000);
    check("full_no_done", 32'(exp_done_q.size()), 1);
    ready = 1'b1;
    wait_idle(400, "full");
    check("full_cnt", 32'(log_evt.size()), 256);
    if (log_evt.size() == 256) check("full_last", 32'(log_evt[255]), 32'h0ff);

    // Second enable while core 0 still scans is dropped and counted.
    clear_log();
    add_frame(0, 256'h3ff);
    fire(2'b01, 256'h3ff, '0);
    tick(2);
    fire(2'b01, 256'h1 << 100, '0);
    model_ovr++;
    wait_idle(100, "ovr");
    check("ovr_val", 32'(ovr), 1);
    check("ovr_cnt", 32'(log_evt.size()), 10);

    // Both cores drop on one edge; core 1 goes first since core 0 was served last.
    clear_log();
    add_frame(1, 256'h20);
    add_frame(0, 256'hf);
    fire(2'b11, 256'hf, 256'h20);
    fire(2'b11, 256'hf0, 256'h40);
    model_ovr += 2;
    wait_idle(100, "ovr2");
    check("ovr2_val", 32'(ovr), 3);
    if (log_evt.size() > 0) check("ovr2_first", 32'(log_evt[0]), 32'h105);

    // Zero vector on core 1: no events, done two cycles after the enable.
    clear_log();
    exp_done_q.push_back(1);
    fire(2'b10, '0, '0);
    check("zero_busy0", 32'(busy), 1);
    tick();
    check("zero_busy1", 32'(busy), 1);
    tick();
    check("zero_busy2", 32'(busy), 0);
    wait_idle(20, "zero");
    check("zero_done_cyc", 32'(done_cyc[1]), 32'(en_cyc + 2));
    check("zero_cnt", 32'(log_evt.size()), 0);

    // Reset mid-scan clears everything immediately.
    ready = 1'b0;
    fire(2'b01, 256'hfffff, '0);
    tick(20);
    #2;
    rst = 1'b1;
    model_ovr = 0;
    exp_q.delete();
    exp_done_q.delete();
    #1;
    check("mrst_valid", 32'(evt_valid), 0);
    check("mrst_data", 32'(evt_data), 0);
    check("mrst_done", 32'(fd), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_ovr", 32'(ovr), 0);
    tick();
    rst = 1'b0;
    tick();
    clear_log();
    ready = 1'b1;
    add_frame(0, 256'h60);
    fire(2'b01, 256'h60, '0);
    wait_idle(50, "post_rst");
    check("post_rst_cnt", 32'(log_evt.size()), 2);
    if (log_evt.size() == 2) begin
      check("post_rst_e0", 32'(log_evt[0]), 32'h005);
      check("post_rst_e1", 32'(log_evt[1]), 32'h006);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
